// File: rtl/lsu_if.sv
// Memory-stage bundle: instruction issue from execute, data-memory port,
// and the registered write-back record.
interface lsu_if #(
  parameter int TID_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mem_op;
  logic [31:0]      in_addr;
  logic [31:0]      in_wdata;
  logic [4:0]       in_rd;
  logic [TID_W-1:0] in_tid;
  logic             in_ovf;

  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  logic             wb_valid;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [TID_W-1:0] wb_tid;
  logic [31:0]      wb_data;
  logic [1:0]       wb_exc;

  // master: the LSU itself; slave: execute stage, data memory and write-back
  modport master (
    input  in_valid, in_mem_op, in_addr, in_wdata, in_rd, in_tid, in_ovf,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_we, wb_rd, wb_tid, wb_data, wb_exc
  );

  modport slave (
    output in_valid, in_mem_op, in_addr, in_wdata, in_rd, in_tid, in_ovf,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_we, wb_rd, wb_tid, wb_data, wb_exc
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: passes non-memory results through, flags misaligned
// accesses, and runs word loads/stores over a req/gnt/rvalid port with timeout.
module lsu #(
  parameter int TID_W   = 2,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [1:0] {
    EXC_OK       = 2'b00,
    EXC_OVF      = 2'b01,
    EXC_MISALIGN = 2'b10,
    EXC_BUS      = 2'b11
  } exc_t;

  localparam logic [1:0]  OP_LOAD  = 2'b01;
  localparam logic [1:0]  OP_STORE = 2'b10;
  localparam logic [15:0] LIMIT    = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             accept;

  logic [31:0]      addr_q, wdata_q;
  logic [4:0]       rd_q;
  logic [TID_W-1:0] tid_q;
  logic             store_q;

  logic             wb_valid_q, wb_valid_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [TID_W-1:0] wb_tid_q, wb_tid_d;
  logic [31:0]      wb_data_q, wb_data_d;
  exc_t             wb_exc_q, wb_exc_d;

  assign bus.in_ready  = (state_q == IDLE);
  assign accept        = bus.in_valid & bus.in_ready;

  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = (state_q == REQ) & store_q;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;

  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_tid    = wb_tid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_exc    = wb_exc_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_tid_d   = wb_tid_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wb_rd_d   = bus.in_rd;
          wb_tid_d  = bus.in_tid;
          wb_data_d = bus.in_addr;
          if (bus.in_mem_op == OP_LOAD || bus.in_mem_op == OP_STORE) begin
            if (bus.in_addr[1:0] != 2'b00) begin
              wb_valid_d = 1'b1;
              wb_exc_d   = EXC_MISALIGN;
            end else begin
              state_d = REQ;
            end
          end else begin
            // Plain ALU result (including the reserved op code)
            wb_valid_d = 1'b1;
            wb_we_d    = ~bus.in_ovf;
            wb_exc_d   = bus.in_ovf ? EXC_OVF : EXC_OK;
          end
        end
      end

      REQ: begin
        if (bus.mem_gnt) begin
          if (store_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_tid_d   = tid_q;
            wb_data_d  = addr_q;
            wb_exc_d   = EXC_OK;
            state_d    = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        // A response in the limit cycle still wins over the bus error
        if (bus.mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b1;
          wb_rd_d    = rd_q;
          wb_tid_d   = tid_q;
          wb_data_d  = bus.mem_rdata;
          wb_exc_d   = EXC_OK;
          state_d    = IDLE;
        end else if (cnt_q == LIMIT) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_tid_d   = tid_q;
          wb_data_d  = '0;
          wb_exc_d   = EXC_BUS;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_tid_q   <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= EXC_OK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_tid_q   <= wb_tid_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  // Instruction payload, captured only on acceptance and held through REQ/WAIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      tid_q   <= '0;
      store_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.in_addr;
      wdata_q <= bus.in_wdata;
      rd_q    <= bus.in_rd;
      tid_q   <= bus.in_tid;
      store_q <= (bus.in_mem_op == OP_STORE);
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of single-cycle records plus hand-written
// load/store/timeout/reset sequences with TIMEOUT=4.
module tb_lsu;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  lsu_if #(.TID_W(2)) bus ();

  lsu #(.TID_W(2), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [1:0]  tid;
    logic        ovf;
    logic        exp_we;
    logic [1:0]  exp_exc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction for a single cycle, then scramble the inputs
  task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [1:0] tid);
    bus.in_valid  = 1'b1;
    bus.in_mem_op = op;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_rd     = rd;
    bus.in_tid    = tid;
    bus.in_ovf    = 1'b0;
    step();
    bus.in_valid  = 1'b0;
    bus.in_addr   = 32'hFFFF_FFFF;
    bus.in_wdata  = 32'h1111_1111;
    bus.in_rd     = 5'd0;
    bus.in_tid    = 2'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, bus.in_ready, 1);
    check({tag, " mem_req"}, bus.mem_req, 0);
    check({tag, " mem_we"}, bus.mem_we, 0);
    check({tag, " mem_addr"}, bus.mem_addr, 0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 0);
    check({tag, " wb_valid"}, bus.wb_valid, 0);
    check({tag, " wb_we"}, bus.wb_we, 0);
    check({tag, " wb_rd"}, bus.wb_rd, 0);
    check({tag, " wb_tid"}, bus.wb_tid, 0);
    check({tag, " wb_data"}, bus.wb_data, 0);
    check({tag, " wb_exc"}, bus.wb_exc, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            op     addr           rd     tid  ovf   we    exc
    vecs[0]  = '{2'b00, 32'h0000_1234, 5'd5,  2'd2, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{2'b00, 32'h0000_1234, 5'd5,  2'd2, 1'b0, 1'b1, 2'b00};
    vecs[2]  = '{2'b00, 32'h0000_1234, 5'd5,  2'd2, 1'b0, 1'b1, 2'b00};
    vecs[3]  = '{2'b00, 32'h0000_1234, 5'd5,  2'd2, 1'b1, 1'b0, 2'b01};
    vecs[4]  = '{2'b00, 32'h0000_1234, 5'd5,  2'd2, 1'b1, 1'b0, 2'b01};
    vecs[5]  = '{2'b00, 32'h0000_1234, 5'd5,  2'd2, 1'b1, 1'b0, 2'b01};
    vecs[6]  = '{2'b11, 32'h0000_BEEF, 5'd6,  2'd1, 1'b0, 1'b1, 2'b00};
    vecs[7]  = '{2'b11, 32'h0000_0055, 5'd7,  2'd3, 1'b1, 1'b0, 2'b01};
    vecs[8]  = '{2'b01, 32'h0000_0203, 5'd8,  2'd0, 1'b0, 1'b0, 2'b10};
    vecs[9]  = '{2'b10, 32'h0000_0206, 5'd9,  2'd1, 1'b0, 1'b0, 2'b10};
    vecs[10] = '{2'b01, 32'h0000_0201, 5'd10, 2'd2, 1'b1, 1'b0, 2'b10};
    vecs[11] = '{2'b00, 32'hFFFF_FFFC, 5'd31, 2'd3, 1'b0, 1'b1, 2'b00};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_mem_op  = 2'b00;
    bus.in_addr    = '0;
    bus.in_wdata   = '0;
    bus.in_rd      = '0;
    bus.in_tid     = '0;
    bus.in_ovf     = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    @(negedge clk);
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Back-to-back single-cycle records: pass-through, overflow, reserved, misaligned
    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_mem_op = vecs[i].op;
      bus.in_addr   = vecs[i].addr;
      bus.in_wdata  = 32'h0BAD_0BAD;
      bus.in_rd     = vecs[i].rd;
      bus.in_tid    = vecs[i].tid;
      bus.in_ovf    = vecs[i].ovf;
      step();
      check($sformatf("vec%0d wb_valid", i), bus.wb_valid, 1);
      check($sformatf("vec%0d wb_data", i), bus.wb_data, vecs[i].addr);
      check($sformatf("vec%0d wb_we", i), bus.wb_we, vecs[i].exp_we);
      check($sformatf("vec%0d wb_rd", i), bus.wb_rd, vecs[i].rd);
      check($sformatf("vec%0d wb_tid", i), bus.wb_tid, vecs[i].tid);
      check($sformatf("vec%0d wb_exc", i), bus.wb_exc, vecs[i].exp_exc);
      check($sformatf("vec%0d mem_req", i), bus.mem_req, 0);
    end
    bus.in_valid = 1'b0;
    bus.in_ovf   = 1'b0;
    step();
    check("vec idle wb_valid", bus.wb_valid, 0);

    // Aligned load, grant held off two cycles, response on the third WAIT cycle
    issue(2'b01, 32'h0000_0100, 32'h0, 5'd7, 2'd1);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ld req%0d mem_req", c), bus.mem_req, 1);
      check($sformatf("ld req%0d mem_addr", c), bus.mem_addr, 32'h100);
      check($sformatf("ld req%0d mem_we", c), bus.mem_we, 0);
      check($sformatf("ld req%0d in_ready", c), bus.in_ready, 0);
      check($sformatf("ld req%0d wb_valid", c), bus.wb_valid, 0);
      step();
    end
    check("ld gnt mem_req", bus.mem_req, 1);
    check("ld gnt mem_addr", bus.mem_addr, 32'h100);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("ld wait%0d mem_req", c), bus.mem_req, 0);
      check($sformatf("ld wait%0d in_ready", c), bus.in_ready, 0);
      check($sformatf("ld wait%0d wb_valid", c), bus.wb_valid, 0);
      if (c == 2) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
      end
      step();
    end
    bus.mem_rvalid = 1'b0;
    check("ld wb_valid", bus.wb_valid, 1);
    check("ld wb_data", bus.wb_data, 32'hDEAD_BEEF);
    check("ld wb_we", bus.wb_we, 1);
    check("ld wb_rd", bus.wb_rd, 7);
    check("ld wb_tid", bus.wb_tid, 1);
    check("ld wb_exc", bus.wb_exc, 0);
    check("ld in_ready", bus.in_ready, 1);
    step();
    check("ld pulse wb_valid", bus.wb_valid, 0);

    // Store with immediate grant
    issue(2'b10, 32'h0000_0204, 32'hA5A5_A5A5, 5'd3, 2'd2);
    check("st mem_req", bus.mem_req, 1);
    check("st mem_we", bus.mem_we, 1);
    check("st mem_addr", bus.mem_addr, 32'h204);
    check("st mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    check("st early wb_valid", bus.wb_valid, 0);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("st wb_valid", bus.wb_valid, 1);
    check("st wb_we", bus.wb_we, 0);
    check("st wb_exc", bus.wb_exc, 0);
    check("st wb_rd", bus.wb_rd, 3);
    check("st mem_req after", bus.mem_req, 0);
    check("st in_ready", bus.in_ready, 1);

    // Timeout: granted load, no response for four WAIT cycles
    issue(2'b01, 32'h0000_0300, 32'h0, 5'd4, 2'd3);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("to wait%0d wb_valid", c), bus.wb_valid, 0);
      check($sformatf("to wait%0d in_ready", c), bus.in_ready, 0);
      step();
    end
    check("to wb_valid", bus.wb_valid, 1);
    check("to wb_exc", bus.wb_exc, 2'b11);
    check("to wb_data", bus.wb_data, 0);
    check("to wb_we", bus.wb_we, 0);
    check("to wb_rd", bus.wb_rd, 4);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("to late%0d wb_valid", c), bus.wb_valid, 0);
      check($sformatf("to late%0d in_ready", c), bus.in_ready, 1);
    end
    bus.mem_rvalid = 1'b0;

    // Response arriving in the same cycle the counter reaches its limit
    issue(2'b01, 32'h0000_0304, 32'h0, 5'd9, 2'd0);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("lim wait%0d wb_valid", c), bus.wb_valid, 0);
      if (c == 3) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1357_9BDF;
      end
      step();
    end
    bus.mem_rvalid = 1'b0;
    check("lim wb_valid", bus.wb_valid, 1);
    check("lim wb_exc", bus.wb_exc, 0);
    check("lim wb_data", bus.wb_data, 32'h1357_9BDF);
    check("lim wb_we", bus.wb_we, 1);

    // Reset in the middle of WAIT, stray response, then a clean load
    issue(2'b01, 32'h0000_0400, 32'h0, 5'd11, 2'd1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    step();
    check("rst pre in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    step();
    check_reset_outputs("midrst");
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h9999_9999;
    step();
    bus.mem_rvalid = 1'b0;
    check("stray wb_valid", bus.wb_valid, 0);
    check("stray in_ready", bus.in_ready, 1);

    // rvalid alongside the grant is too early and must be ignored
    issue(2'b01, 32'h0000_0500, 32'h0, 5'd12, 2'd3);
    check("rec mem_req", bus.mem_req, 1);
    check("rec mem_addr", bus.mem_addr, 32'h500);
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    step();
    bus.mem_gnt    = 1'b0;
    check("rec early wb_valid", bus.wb_valid, 0);
    bus.mem_rdata  = 32'hCAFE_F00D;
    step();
    bus.mem_rvalid = 1'b0;
    check("rec wb_valid", bus.wb_valid, 1);
    check("rec wb_data", bus.wb_data, 32'hCAFE_F00D);
    check("rec wb_we", bus.wb_we, 1);
    check("rec wb_rd", bus.wb_rd, 12);
    check("rec wb_tid", bus.wb_tid, 3);
    check("rec wb_exc", bus.wb_exc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
